// File: rtl/param_mem_arbiter.sv
// param_mem_arbiter: shares the single-port operator parameter RAM between
// synth reads (always win) and buffered SPI host writes drained into free slots.
module param_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int ATOMIC     = 1
) (
    input  logic                          IO_main_clk,
    input  logic                          IO_reset,
    input  logic                          frame_busy,
    input  logic                          synth_rd_en,
    input  logic [ADDR_W-1:0]             synth_rd_addr,
    output logic                          synth_rd_valid,
    output logic [DATA_W-1:0]             synth_rd_value,
    input  logic                          host_wr_valid,
    output logic                          host_wr_ready,
    input  logic [ADDR_W-1:0]             host_wr_addr,
    input  logic [DATA_W-1:0]             host_wr_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drain_active,
    output logic [15:0]                   stall_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [ADDR_W-1:0]   last_addr;
    logic [DATA_W-1:0]   last_wdata;
    logic                fifo_empty;
    logic                window;
    logic                push;
    logic                pop;

    assign fifo_empty     = (fifo_level == '0);
    assign window         = (ATOMIC == 0) || !frame_busy;
    assign host_wr_ready  = (fifo_level < FULL_LVL);
    assign push           = host_wr_valid && host_wr_ready;
    assign pop            = (state == DRAIN) && !fifo_empty && !synth_rd_en && window;
    assign synth_rd_value = mem_rdata;

    // RAM port mux: synth read first, then a drain write, else hold the address
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        if (synth_rd_en) begin
            mem_addr = synth_rd_addr;
        end else if (pop) begin
            mem_we    = 1'b1;
            mem_addr  = fifo_addr[rd_ptr];
            mem_wdata = fifo_data[rd_ptr];
        end
    end

    // FIFO storage; contents need no reset since the pointers qualify them
    always_ff @(posedge IO_main_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_wr_addr;
            fifo_data[wr_ptr] <= host_wr_data;
        end
    end

    // Pointers, level, read-valid pipeline, held RAM port, stall counter and FSM
    always_ff @(posedge IO_main_clk or posedge IO_reset) begin
        if (IO_reset) begin
            state          <= IDLE;
            drain_active   <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            synth_rd_valid <= 1'b0;
            last_addr      <= '0;
            last_wdata     <= '0;
            stall_cnt      <= '0;
        end else begin
            synth_rd_valid <= synth_rd_en;
            last_addr      <= mem_addr;
            last_wdata     <= mem_wdata;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;

            if (!fifo_empty && !pop && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;

            case (state)
                IDLE: begin
                    // A push this cycle counts as non-empty so the write can land next cycle
                    if ((!fifo_empty || push) && window) begin
                        state        <= DRAIN;
                        drain_active <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!window || (pop && (fifo_level == ONE_LVL) && !push) ||
                        (fifo_empty && !push)) begin
                        state        <= IDLE;
                        drain_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    drain_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_mem_arbiter.sv
// tb_param_mem_arbiter: scoreboard bench for param_mem_arbiter; one instance
// with ATOMIC=1 (a) and one with ATOMIC=0 (b), each backed by a RAM model.
module tb_param_mem_arbiter;

    typedef struct {
        logic [9:0]  a;
        logic [17:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    wr_t         exp_wr_a[$];
    wr_t         exp_wr_b[$];
    logic [17:0] exp_rd_a[$];
    logic [17:0] exp_rd_b[$];

    // instance a signals
    logic        fb_a = 1'b0, rd_en_a = 1'b0, hv_a = 1'b0;
    logic [9:0]  rd_addr_a = '0, ha_a = '0;
    logic [17:0] hd_a = '0;
    logic        rd_valid_a, rdy_a, we_a, drain_a;
    logic [17:0] rd_value_a, wdata_a, rdata_a;
    logic [9:0]  maddr_a;
    logic [2:0]  lvl_a;
    logic [15:0] stall_a;

    // instance b signals
    logic        fb_b = 1'b0, rd_en_b = 1'b0, hv_b = 1'b0;
    logic [9:0]  rd_addr_b = '0, ha_b = '0;
    logic [17:0] hd_b = '0;
    logic        rd_valid_b, rdy_b, we_b, drain_b;
    logic [17:0] rd_value_b, wdata_b, rdata_b;
    logic [9:0]  maddr_b;
    logic [2:0]  lvl_b;
    logic [15:0] stall_b;

    logic [17:0] ram_a [1024];
    logic [17:0] ram_b [1024];

    param_mem_arbiter #(.ADDR_W(10), .DATA_W(18), .FIFO_DEPTH(4), .ATOMIC(1)) u_dut_a (
        .IO_main_clk(clk), .IO_reset(rst), .frame_busy(fb_a),
        .synth_rd_en(rd_en_a), .synth_rd_addr(rd_addr_a),
        .synth_rd_valid(rd_valid_a), .synth_rd_value(rd_value_a),
        .host_wr_valid(hv_a), .host_wr_ready(rdy_a),
        .host_wr_addr(ha_a), .host_wr_data(hd_a),
        .mem_addr(maddr_a), .mem_we(we_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
        .fifo_level(lvl_a), .drain_active(drain_a), .stall_cnt(stall_a)
    );

    param_mem_arbiter #(.ADDR_W(10), .DATA_W(18), .FIFO_DEPTH(4), .ATOMIC(0)) u_dut_b (
        .IO_main_clk(clk), .IO_reset(rst), .frame_busy(fb_b),
        .synth_rd_en(rd_en_b), .synth_rd_addr(rd_addr_b),
        .synth_rd_valid(rd_valid_b), .synth_rd_value(rd_value_b),
        .host_wr_valid(hv_b), .host_wr_ready(rdy_b),
        .host_wr_addr(ha_b), .host_wr_data(hd_b),
        .mem_addr(maddr_b), .mem_we(we_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .fifo_level(lvl_b), .drain_active(drain_b), .stall_cnt(stall_b)
    );

    // RAM models: registered read, write on mem_we
    always @(posedge clk) begin
        if (we_a) ram_a[maddr_a] <= wdata_a;
        rdata_a <= ram_a[maddr_a];
        if (we_b) ram_b[maddr_b] <= wdata_b;
        rdata_b <= ram_b[maddr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RAM write and every read-valid is checked against the queues
    always @(negedge clk) begin
        wr_t w;
        if (we_a) begin
            if (exp_wr_a.size() == 0) chk("a_unexpected_write", 32'(maddr_a), 32'h0);
            else begin
                w = exp_wr_a.pop_front();
                chk("a_wr_addr", 32'(maddr_a), 32'(w.a));
                chk("a_wr_data", 32'(wdata_a), 32'(w.d));
            end
        end
        if (we_b) begin
            if (exp_wr_b.size() == 0) chk("b_unexpected_write", 32'(maddr_b), 32'h0);
            else begin
                w = exp_wr_b.pop_front();
                chk("b_wr_addr", 32'(maddr_b), 32'(w.a));
                chk("b_wr_data", 32'(wdata_b), 32'(w.d));
            end
        end
        if (rd_valid_a) begin
            if (exp_rd_a.size() == 0) chk("a_unexpected_rd_valid", 32'h1, 32'h0);
            else chk("a_rd_value", 32'(rd_value_a), 32'(exp_rd_a.pop_front()));
        end
        if (rd_valid_b) begin
            if (exp_rd_b.size() == 0) chk("b_unexpected_rd_valid", 32'h1, 32'h0);
            else chk("b_rd_value", 32'(rd_value_b), 32'(exp_rd_b.pop_front()));
        end
    end

    task automatic push_a(input logic [9:0] a, input logic [17:0] d, input bit expect_write);
        hv_a = 1'b1; ha_a = a; hd_a = d;
        if (expect_write) exp_wr_a.push_back('{a: a, d: d});
    endtask

    task automatic push_b(input logic [9:0] a, input logic [17:0] d);
        hv_b = 1'b1; ha_b = a; hd_b = d;
        exp_wr_b.push_back('{a: a, d: d});
    endtask

    initial begin
        int guard;
        int wr_seen;
        logic [17:0] d4 [8];
        for (int k = 0; k < 8; k++) d4[k] = 18'h20000 | 18'(k * 'h111);

        // ---------------- reset values ----------------
        @(negedge clk);
        chk("rst_level", 32'(lvl_a), 32'h0);
        chk("rst_ready", 32'(rdy_a), 32'h1);
        chk("rst_we", 32'(we_a), 32'h0);
        chk("rst_addr", 32'(maddr_a), 32'h0);
        chk("rst_wdata", 32'(wdata_a), 32'h0);
        chk("rst_drain", 32'(drain_a), 32'h0);
        chk("rst_stall", 32'(stall_a), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid_a), 32'h0);
        step(); rst = 1'b0;
        step();

        // ---------------- test 1: 3 back-to-back writes, window open ----------------
        push_a(10'h010, 18'h3FFFF, 1'b1);
        @(negedge clk); chk("t1_we_c0", 32'(we_a), 32'h0); chk("t1_rdy_c0", 32'(rdy_a), 32'h1);
        step(); push_a(10'h011, 18'h00001, 1'b1);
        @(negedge clk); chk("t1_we_c1", 32'(we_a), 32'h1); chk("t1_drain_c1", 32'(drain_a), 32'h1);
        step(); push_a(10'h012, 18'h12345, 1'b1);
        @(negedge clk); chk("t1_we_c2", 32'(we_a), 32'h1); chk("t1_level_c2", 32'(lvl_a), 32'h1);
        step(); hv_a = 1'b0;
        @(negedge clk); chk("t1_we_c3", 32'(we_a), 32'h1); chk("t1_drain_c3", 32'(drain_a), 32'h1);
        step();
        @(negedge clk);
        chk("t1_we_c4", 32'(we_a), 32'h0);
        chk("t1_level_end", 32'(lvl_a), 32'h0);
        chk("t1_drain_end", 32'(drain_a), 32'h0);
        chk("t1_stall", 32'(stall_a), 32'h0);

        // ---------------- test 2: blocked by frame, fill, then drain ----------------
        fb_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(); push_a(10'h040 + 10'(k), 18'h10000 + 18'(k), 1'b1);
            @(negedge clk);
            chk("t2_rdy_fill", 32'(rdy_a), 32'h1);
            chk("t2_we_fill", 32'(we_a), 32'h0);
        end
        step(); hv_a = 1'b0;
        @(negedge clk);
        chk("t2_rdy_full", 32'(rdy_a), 32'h0);
        chk("t2_level_full", 32'(lvl_a), 32'h4);
        chk("t2_we_full", 32'(we_a), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(); @(negedge clk); chk("t2_we_blocked", 32'(we_a), 32'h0);
        end
        chk("t2_stall_7", 32'(stall_a), 32'd7);
        step(); fb_a = 1'b0;
        @(negedge clk); chk("t2_we_idle", 32'(we_a), 32'h0); chk("t2_rdy_c9", 32'(rdy_a), 32'h0);
        step(); @(negedge clk);
        chk("t2_we_pop0", 32'(we_a), 32'h1); chk("t2_rdy_pop0", 32'(rdy_a), 32'h0);
        chk("t2_drain", 32'(drain_a), 32'h1);
        step(); @(negedge clk);
        chk("t2_we_pop1", 32'(we_a), 32'h1); chk("t2_rdy_after_pop", 32'(rdy_a), 32'h1);
        step(); @(negedge clk); chk("t2_we_pop2", 32'(we_a), 32'h1);
        step(); @(negedge clk); chk("t2_we_pop3", 32'(we_a), 32'h1);
        step(); @(negedge clk);
        chk("t2_we_done", 32'(we_a), 32'h0);
        chk("t2_level_done", 32'(lvl_a), 32'h0);
        chk("t2_drain_done", 32'(drain_a), 32'h0);
        chk("t2_stall_9", 32'(stall_a), 32'd9);

        // ---------------- test 3 (ATOMIC=0): reads interleaved with drain ----------------
        step(); push_b(10'h030, 18'h11111);
        step(); push_b(10'h031, 18'h22222);
        step(); hv_b = 1'b0;
        step(); step();
        step(); push_b(10'h020, 18'h0AAAA); rd_en_b = 1'b1; rd_addr_b = 10'h030;
        exp_rd_b.push_back(18'h11111);
        @(negedge clk); chk("t3_we_c0", 32'(we_b), 32'h0); chk("t3_rv_c0", 32'(rd_valid_b), 32'h0);
        step(); push_b(10'h021, 18'h15555); rd_en_b = 1'b0;
        @(negedge clk); chk("t3_we_c1", 32'(we_b), 32'h1); chk("t3_rv_c1", 32'(rd_valid_b), 32'h1);
        step(); hv_b = 1'b0; rd_en_b = 1'b1; rd_addr_b = 10'h031;
        exp_rd_b.push_back(18'h22222);
        @(negedge clk); chk("t3_we_c2", 32'(we_b), 32'h0); chk("t3_rv_c2", 32'(rd_valid_b), 32'h0);
        step(); rd_en_b = 1'b0;
        @(negedge clk); chk("t3_we_c3", 32'(we_b), 32'h1); chk("t3_rv_c3", 32'(rd_valid_b), 32'h1);
        step(); rd_en_b = 1'b1; rd_addr_b = 10'h020;
        exp_rd_b.push_back(18'h0AAAA);
        @(negedge clk); chk("t3_we_c4", 32'(we_b), 32'h0); chk("t3_level_c4", 32'(lvl_b), 32'h0);
        step(); rd_en_b = 1'b0;
        @(negedge clk); chk("t3_rv_c5", 32'(rd_valid_b), 32'h1); chk("t3_we_c5", 32'(we_b), 32'h0);

        // ---------------- test 4: full FIFO, valid held through drain ----------------
        fb_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(); push_a(10'h100 + 10'(k), d4[k], 1'b0);
            exp_wr_a.push_back('{a: 10'h100 + 10'(k), d: d4[k]});
        end
        for (int k = 4; k < 8; k++) begin
            step();
            if (k == 4) fb_a = 1'b0;
            hv_a = 1'b1; ha_a = 10'h100 + 10'(k); hd_a = d4[k];
            guard = 0;
            @(negedge clk);
            while (!rdy_a && guard < 20) begin
                step(); @(negedge clk); guard++;
            end
            chk("t4_handshake_timeout", 32'(guard < 20), 32'h1);
            exp_wr_a.push_back('{a: 10'h100 + 10'(k), d: d4[k]});
        end
        step(); hv_a = 1'b0;
        guard = 0;
        @(negedge clk);
        while ((lvl_a != 0 || drain_a) && guard < 30) begin
            step(); @(negedge clk); guard++;
        end
        chk("t4_drain_timeout", 32'(guard < 30), 32'h1);
        chk("t4_all_written", 32'(exp_wr_a.size()), 32'h0);
        fb_a = 1'b1;
        step(); rd_en_a = 1'b1; rd_addr_a = 10'h100; exp_rd_a.push_back(d4[0]);
        step(); rd_addr_a = 10'h107; exp_rd_a.push_back(d4[7]);
        step(); rd_en_a = 1'b0;
        step(); fb_a = 1'b0;

        // ---------------- test 5: reset mid-drain ----------------
        fb_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(); push_a(10'h200 + 10'(k), 18'h30000 + 18'(k), k == 0);
        end
        step(); hv_a = 1'b0; fb_a = 1'b0;
        step();
        @(negedge clk); chk("t5_first_write", 32'(we_a), 32'h1);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_level", 32'(lvl_a), 32'h0);
        chk("t5_rst_we", 32'(we_a), 32'h0);
        chk("t5_rst_drain", 32'(drain_a), 32'h0);
        chk("t5_rst_ready", 32'(rdy_a), 32'h1);
        chk("t5_rst_stall", 32'(stall_a), 32'h0);
        step(); rst = 1'b0;
        wr_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); if (we_a) wr_seen++;
            step();
        end
        chk("t5_no_stale_write", 32'(wr_seen), 32'h0);

        // ---------------- test 6: stall counter saturation ----------------
        fb_a = 1'b1;
        step(); push_a(10'h3FF, 18'h15A5A, 1'b1);
        step(); hv_a = 1'b0;
        repeat (70000) step();
        @(negedge clk);
        chk("t6_stall_sat", 32'(stall_a), 32'hFFFF);
        step(); step();
        @(negedge clk);
        chk("t6_stall_hold", 32'(stall_a), 32'hFFFF);
        step(); fb_a = 1'b0;
        repeat (5) step();

        @(negedge clk);
        chk("end_wr_a_empty", 32'(exp_wr_a.size()), 32'h0);
        chk("end_wr_b_empty", 32'(exp_wr_b.size()), 32'h0);
        chk("end_rd_a_empty", 32'(exp_rd_a.size()), 32'h0);
        chk("end_rd_b_empty", 32'(exp_rd_b.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_mem_arbiter.md
# param_mem_arbiter

Shares the single-port operator parameter RAM (the memory the synth engine reads through its user-memory address/value pair) between the synth datapath and the SPI host write path. Synth reads always win; host writes are buffered in a small FIFO and drained into free RAM slots. Writes can be restricted to the gap between audio frames, so multi-word parameters (e.g. 22-bit phase increments split across two words) never tear mid-frame. Sits between the SPI command decoder and the synth core.

## Interface
- ADDR_W, 10, RAM address width
- DATA_W, 18, RAM word width
- FIFO_DEPTH, 4, host write buffer entries (power of two, ≥2)
- ATOMIC, 1, 1 = drain only while frame_busy=0; 0 = drain in any slot the synth leaves free

- IO_main_clk  in  1  system clock; all logic rising-edge
- IO_reset  in  1  reset, asynchronous, active-high
- frame_busy  in  1  high while the synth dispatcher is running an audio frame
- synth_rd_en  in  1  synth read request this cycle
- synth_rd_addr  in  ADDR_W  synth read address
- synth_rd_valid  out  1  synth_rd_value valid (one cycle after synth_rd_en)
- synth_rd_value  out  DATA_W  read data (pass-through of mem_rdata)
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  FIFO can accept
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  DATA_W  host write data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle registered latency
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries buffered
- drain_active  out  1  high in DRAIN state
- stall_cnt  out  16  saturating count of cycles with a FIFO entry pending but blocked

## Operation
- FIFO push when host_wr_valid && host_wr_ready; host_wr_ready = (fifo_level < FIFO_DEPTH), derived from the registered level only. No push when full, even if a pop happens the same cycle.
- States: IDLE, DRAIN.
  - IDLE -> DRAIN when FIFO is non-empty and the drain window is open. Window: ATOMIC=1 → frame_busy=0; ATOMIC=0 → always.
  - DRAIN -> IDLE when the FIFO becomes empty after a pop, or the window closes (ATOMIC=1 and frame_busy=1).
- Port mux, combinational, in priority order:
  - synth_rd_en=1 → mem_addr=synth_rd_addr, mem_we=0.
  - Else DRAIN and FIFO non-empty → mem_addr/mem_wdata = FIFO head, mem_we=1, pop.
  - Else mem_addr holds its last value and mem_we=0.
- Contract: with ATOMIC=1 the synth never asserts synth_rd_en while frame_busy=0. If it does, the read still wins and the drain pauses that cycle.
- Writes reach RAM in push order. Pending writes are not forwarded to synth reads.
- stall_cnt increments (saturating at 0xFFFF) every cycle with fifo_level>0 and no pop.
- Simultaneous push and pop: level unchanged; the pushed entry goes to the tail.

## Timing
- Reset values: state IDLE, fifo_level 0, FIFO pointers 0, host_wr_ready 1, synth_rd_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, drain_active 0, stall_cnt 0.
- Reset mid-drain: buffered entries are discarded and no further writes are issued. A write already on mem_we when reset asserts is not guaranteed.
- Synth read: synth_rd_en at cycle t → synth_rd_valid=1 and valid synth_rd_value at t+1. Throughput is one read per cycle.
- Host write: push at t → earliest RAM write at t+1, which requires DRAIN entry at t+1 (state register updates at the t→t+1 edge).
- A burst drains one entry per cycle while the window is open and the synth is idle.
- Full FIFO: host_wr_ready=0 from the cycle after the level reaches FIFO_DEPTH. It returns to 1 the cycle after the first pop.
- frame_busy rising while in DRAIN: ATOMIC=1 → no write in that cycle; state is IDLE next cycle.

## Test plan
- ATOMIC=1, frame_busy=0, push 3 writes (addr 0x010/0x011/0x012, data 0x3FFFF/0x00001/0x12345) back-to-back → mem_we high for 3 consecutive cycles starting at first push +1, in order; fifo_level returns to 0; drain_active drops.
- ATOMIC=1, frame_busy=1, push 4 writes → host_wr_ready=0 after the 4th, no mem_we, stall_cnt counts up. Drop frame_busy → 4 writes drain in order, host_wr_ready=1 the cycle after the first pop.
- ATOMIC=0, synth_rd_en on alternating cycles with 2 writes pending → writes land only in the synth-idle cycles; each synth_rd_valid follows its read by exactly 1 cycle with the correct RAM data.
- Full FIFO with host_wr_valid held high during a drain → no entry lost or duplicated; RAM contents match the push sequence exactly.
- Assert IO_reset with 3 entries queued mid-drain → immediately fifo_level=0, mem_we=0, state IDLE; after release no stale write is issued.
- Hold the blocked condition for 70000 cycles → stall_cnt saturates at 0xFFFF and does not wrap.
